hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Pipeline sequencing controller for the 5-stage KGP-RISC core (IF/ID/EX/MEM/WB).
- Tracks in-flight destination registers in its own EX/MEM/WB shadow registers.
- Generates PC/IF-ID enables, IF-ID and ID-EX flushes, and registered forwarding selects for the EX operands.
- Sits beside the decoder: it consumes the ID-stage decode fields, the EX-stage branch resolution (pcsrc) and the data-memory wait signal.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  Pipeline clock; all state updates on the rising edge.
- reset  in  1  Asynchronous, active-low. 0 clears all state immediately.
- id_valid  in  1  The ID stage holds a real instruction.
- id_rs  in  REG_AW  Source A register address of the ID instruction.
- id_rt  in  REG_AW  Source B register address of the ID instruction.
- id_uses_rs  in  1  The ID instruction reads rs.
- id_uses_rt  in  1  The ID instruction reads rt.
- id_regwrite  in  1  The ID instruction writes the register file.
- id_dest  in  REG_AW  Destination register of the ID instruction.
- id_readdmem  in  1  The ID instruction is a load (LD).
- ex_pcsrc  in  1  Branch or jump resolved taken in EX this cycle.
- mem_wait  in  1  Data memory not ready; the whole pipeline must freeze.
- pc_en  out  1  PC register load enable.
- ifid_en  out  1  IF/ID register load enable.
- ifid_flush  out  1  Clear IF/ID to a bubble at the next edge.
- idex_flush  out  1  Load a bubble into ID/EX at the next edge.
- fwd_a  out  2  Registered EX operand-A select: 00 regfile, 01 MEM-stage ALU result, 10 WB-stage writeback data.
- fwd_b  out  2  Same encoding, for operand B.
- stall_count  out  CNT_W  Count of cycles with pc_en=0 while reset=1; saturates at all-ones.

Behaviour:
- State per shadow stage S in {EX, MEM, WB}: v_S, dest_S, wr_S, ld_S.
- A stage "writes r" when v_S & wr_S & (dest_S == r) & (r != 0).
- Register 0 never causes a hazard and never forwards.
- Reset low (asynchronous):
  - All v_S, wr_S, ld_S, dest_S = 0; fwd_a = fwd_b = 00; stall_count = 0.
  - Combinational outputs are forced while reset is low: pc_en = 0, ifid_en = 0, ifid_flush = 0, idex_flush = 0.
- Load-use hazard (luh): id_valid & ld_EX & (EX writes id_rs with id_uses_rs, or EX writes id_rt with id_uses_rt).
- Per-cycle decision, combinational, in priority order:
  1. mem_wait=1 (FREEZE): pc_en = 0, ifid_en = 0, both flushes = 0. All shadow state, fwd_a/fwd_b and ID-side state hold. mem_wait overrides ex_pcsrc and luh in the same cycle.
  2. ex_pcsrc=1 (FLUSH): pc_en = 1, ifid_en = 1, ifid_flush = 1, idex_flush = 1. The EX entry moves to MEM; the next EX entry is a bubble (v = 0). Any simultaneous luh is ignored because the ID instruction is squashed.
  3. luh=1 (STALL): pc_en = 0, ifid_en = 0, idex_flush = 1, ifid_flush = 0. EX gets a bubble; the EX entry advances to MEM. Exactly 1 bubble per load-use.
  4. Otherwise (RUN): pc_en = 1, ifid_en = 1, no flush. EX <= {id_valid, id_dest, id_regwrite, id_readdmem}.
- In every non-FREEZE cycle: MEM <= EX and WB <= MEM.
- Forward selects are computed from the ID fields against the current EX/MEM entries and registered into fwd_a/fwd_b on RUN edges:
  - EX writes the source -> 01.
  - Else MEM writes the source -> 10.
  - Else -> 00.
  - EX has priority over MEM (youngest producer wins).
  - A source whose uses flag is 0 always gets 00.
- On FLUSH or STALL edges, fwd_a and fwd_b <= 00, since the bubble needs no forwarding.
- Latency: fwd_* are valid in the cycle the instruction occupies EX, one edge after its ID cycle.
- stall_count increments by 1 on any edge where reset=1 and pc_en=0 (FREEZE or STALL). It holds at 2^CNT_W-1 once reached.
- Reset asserted mid-operation: the pipeline state is lost; after release the first cycle is RUN with empty shadows.

Test Plan:
- Reset low with mem_wait=0 and id_valid=1 -> pc_en=0, fwd_a=fwd_b=00, stall_count=0. After release, RUN with pc_en=1.
- ADD r3 (id_dest=3, regwrite) followed next cycle by SUB reading rs=3 -> fwd_a=01 in SUB's EX cycle. With one independent instruction between them -> fwd_a=10. With producer dest=0 -> fwd_a=00.
- LD r5 followed by ADD reading rt=5:
  - Exactly one cycle with pc_en=0, ifid_en=0, idex_flush=1.
  - Then ADD enters EX with fwd_b=10.
  - stall_count=1.
- ex_pcsrc=1 in the same cycle as a luh -> ifid_flush=1, idex_flush=1, pc_en=1, no stall cycle, stall_count unchanged.
- mem_wait=1 for 3 cycles during ex_pcsrc=1 -> pc_en=0 and no flush for those 3 cycles, state held, stall_count +3. The flush occurs on the first cycle after mem_wait drops.
- CNT_W=2, mem_wait=1 for 6 cycles -> stall_count reads 1, 2, 3, 3, 3, 3. Asynchronous reset pulse mid-stall -> stall_count=0 and shadows cleared immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_controller.sv
// Sequencing controller for the 5-stage KGP-RISC pipeline: memory freeze, branch
// flush, single-bubble load-use stall and registered EX operand forwarding selects.
module hazard_controller #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_regwrite,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_readdmem,
    input  logic              ex_pcsrc,
    input  logic              mem_wait,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic [1:0] {
        ACT_RUN,
        ACT_FLUSH,
        ACT_STALL,
        ACT_FREEZE
    } action_e;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    // Only the EX and MEM shadows are held: forwarding is resolved in the ID cycle
    // against those two, so a WB shadow would be state no output could observe.
    logic              ex_v_q,    ex_v_d;
    logic [REG_AW-1:0] ex_dest_q, ex_dest_d;
    logic              ex_wr_q,   ex_wr_d;
    logic              ex_ld_q,   ex_ld_d;
    logic              mem_v_q,   mem_v_d;
    logic [REG_AW-1:0] mem_dest_q, mem_dest_d;
    logic              mem_wr_q,  mem_wr_d;
    logic [1:0]        fwd_a_q,   fwd_a_d;
    logic [1:0]        fwd_b_q,   fwd_b_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    logic    ex_wr_rs, ex_wr_rt, mem_wr_rs, mem_wr_rt;
    logic    luh;
    action_e action;
    logic    ex_is_bubble;

    function automatic logic writes_reg(input logic              v,
                                        input logic              wr,
                                        input logic [REG_AW-1:0] dest,
                                        input logic [REG_AW-1:0] r);
        return v && wr && (dest == r) && (r != '0);
    endfunction

    function automatic logic [1:0] pick_src(input logic uses,
                                            input logic from_ex,
                                            input logic from_mem);
        if (!uses)         return SEL_RF;
        else if (from_ex)  return SEL_MEM;
        else if (from_mem) return SEL_WB;
        else               return SEL_RF;
    endfunction

    assign ex_wr_rs  = writes_reg(ex_v_q,  ex_wr_q,  ex_dest_q,  id_rs);
    assign ex_wr_rt  = writes_reg(ex_v_q,  ex_wr_q,  ex_dest_q,  id_rt);
    assign mem_wr_rs = writes_reg(mem_v_q, mem_wr_q, mem_dest_q, id_rs);
    assign mem_wr_rt = writes_reg(mem_v_q, mem_wr_q, mem_dest_q, id_rt);

    assign luh = id_valid && ex_ld_q &&
                 ((id_uses_rs && ex_wr_rs) || (id_uses_rt && ex_wr_rt));

    always_comb begin
        if (mem_wait)      action = ACT_FREEZE;
        else if (ex_pcsrc) action = ACT_FLUSH;
        else if (luh)      action = ACT_STALL;
        else               action = ACT_RUN;
    end

    // Enables and flushes are forced inactive for as long as reset is held low.
    assign pc_en      = reset && ((action == ACT_RUN) || (action == ACT_FLUSH));
    assign ifid_en    = pc_en;
    assign ifid_flush = reset && (action == ACT_FLUSH);
    assign idex_flush = reset && ((action == ACT_FLUSH) || (action == ACT_STALL));

    assign ex_is_bubble = (action == ACT_FLUSH) || (action == ACT_STALL);

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no path through
        // this block leaves one unassigned and no latch is inferred.
        ex_v_d     = ex_v_q;
        ex_dest_d  = ex_dest_q;
        ex_wr_d    = ex_wr_q;
        ex_ld_d    = ex_ld_q;
        mem_v_d    = mem_v_q;
        mem_dest_d = mem_dest_q;
        mem_wr_d   = mem_wr_q;
        fwd_a_d    = fwd_a_q;
        fwd_b_d    = fwd_b_q;
        cnt_d      = cnt_q;

        if (action != ACT_FREEZE) begin
            mem_v_d    = ex_v_q;
            mem_dest_d = ex_dest_q;
            mem_wr_d   = ex_wr_q;
            if (ex_is_bubble) begin
                ex_v_d    = 1'b0;
                ex_dest_d = '0;
                ex_wr_d   = 1'b0;
                ex_ld_d   = 1'b0;
                fwd_a_d   = SEL_RF;
                fwd_b_d   = SEL_RF;
            end else begin
                ex_v_d    = id_valid;
                ex_dest_d = id_dest;
                ex_wr_d   = id_regwrite;
                ex_ld_d   = id_readdmem;
                fwd_a_d   = pick_src(id_uses_rs, ex_wr_rs, mem_wr_rs);
                fwd_b_d   = pick_src(id_uses_rt, ex_wr_rt, mem_wr_rt);
            end
        end

        if (!pc_en && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_v_q     <= 1'b0;
            ex_dest_q  <= '0;
            ex_wr_q    <= 1'b0;
            ex_ld_q    <= 1'b0;
            mem_v_q    <= 1'b0;
            mem_dest_q <= '0;
            mem_wr_q   <= 1'b0;
            fwd_a_q    <= SEL_RF;
            fwd_b_q    <= SEL_RF;
            cnt_q      <= '0;
        end else begin
            // NOTE: non-blocking updates make every register sample the pre-edge
            // values, so MEM takes the old EX entry while EX loads the new one.
            ex_v_q     <= ex_v_d;
            ex_dest_q  <= ex_dest_d;
            ex_wr_q    <= ex_wr_d;
            ex_ld_q    <= ex_ld_d;
            mem_v_q    <= mem_v_d;
            mem_dest_q <= mem_dest_d;
            mem_wr_q   <= mem_wr_d;
            fwd_a_q    <= fwd_a_d;
            fwd_b_q    <= fwd_b_d;
            cnt_q      <= cnt_d;
        end
    end

    assign fwd_a       = fwd_a_q;
    assign fwd_b       = fwd_b_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: a pipeline-slot model checked every cycle,
// plus directed sequences with hand-computed expectations (including a CNT_W=2 instance).
module tb_hazard_controller;

    localparam int CNT_MAX = 65535;

    logic       clk = 1'b0;
    logic       reset, reset2;
    logic       id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_readdmem;
    logic [4:0] id_rs, id_rt, id_dest;
    logic       ex_pcsrc, mem_wait, mem_wait2;

    logic        pc_en, ifid_en, ifid_flush, idex_flush;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_count;
    logic        pc_en2, ifid_en2, ifid_flush2, idex_flush2;
    logic [1:0]  fwd_a2, fwd_b2;
    logic [1:0]  stall_count2;

    always #5 clk = ~clk;

    hazard_controller #(.REG_AW(5), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regwrite(id_regwrite),
        .id_dest(id_dest), .id_readdmem(id_readdmem), .ex_pcsrc(ex_pcsrc),
        .mem_wait(mem_wait), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
    );

    hazard_controller #(.REG_AW(5), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset2), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regwrite(id_regwrite),
        .id_dest(id_dest), .id_readdmem(id_readdmem), .ex_pcsrc(ex_pcsrc),
        .mem_wait(mem_wait2), .pc_en(pc_en2), .ifid_en(ifid_en2), .ifid_flush(ifid_flush2),
        .idex_flush(idex_flush2), .fwd_a(fwd_a2), .fwd_b(fwd_b2), .stall_count(stall_count2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: slots 0=EX, 1=MEM, 2=WB ----------------
    typedef struct {
        bit       v;
        bit [4:0] dest;
        bit       wr;
        bit       ld;
    } slot_t;

    slot_t pipe [3];
    int    m_fwd_a, m_fwd_b, m_cnt;
    bit    cmp_on;

    function automatic bit produces(input slot_t s, input bit [4:0] r);
        return s.v && s.wr && (s.dest == r) && (r != 5'd0);
    endfunction

    function automatic int src_sel(input bit uses, input bit [4:0] r);
        if (!uses)                return 0;
        if (produces(pipe[0], r)) return 1;
        if (produces(pipe[1], r)) return 2;
        return 0;
    endfunction

    function automatic bit m_luh();
        return id_valid && pipe[0].ld &&
               ((id_uses_rs && produces(pipe[0], id_rs)) ||
                (id_uses_rt && produces(pipe[0], id_rt)));
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) pipe[i] = '{v: 0, dest: 0, wr: 0, ld: 0};
            m_fwd_a = 0;
            m_fwd_b = 0;
            m_cnt   = 0;
        end else if (mem_wait) begin
            if (m_cnt < CNT_MAX) m_cnt++;
        end else begin
            bit hz;
            int fa, fb;
            hz = m_luh();
            fa = src_sel(id_uses_rs, id_rs);
            fb = src_sel(id_uses_rt, id_rt);
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (ex_pcsrc || hz) begin
                pipe[0] = '{v: 0, dest: 0, wr: 0, ld: 0};
                m_fwd_a = 0;
                m_fwd_b = 0;
                if (!ex_pcsrc && m_cnt < CNT_MAX) m_cnt++;
            end else begin
                pipe[0] = '{v: id_valid, dest: id_dest, wr: id_regwrite, ld: id_readdmem};
                m_fwd_a = fa;
                m_fwd_b = fb;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            int e_pc, e_iff, e_idf;
            e_pc  = (reset && !mem_wait && (ex_pcsrc || !m_luh())) ? 1 : 0;
            e_iff = (reset && !mem_wait && ex_pcsrc) ? 1 : 0;
            e_idf = (reset && !mem_wait && (ex_pcsrc || m_luh())) ? 1 : 0;
            check("m_pc_en",       32'(pc_en),       e_pc);
            check("m_ifid_en",     32'(ifid_en),     e_pc);
            check("m_ifid_flush",  32'(ifid_flush),  e_iff);
            check("m_idex_flush",  32'(idex_flush),  e_idf);
            check("m_fwd_a",       32'(fwd_a),       m_fwd_a);
            check("m_fwd_b",       32'(fwd_b),       m_fwd_b);
            check("m_stall_count", 32'(stall_count), m_cnt);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_in(input bit v, input bit [4:0] rs, input bit urs,
                          input bit [4:0] rt, input bit urt, input bit rw,
                          input bit [4:0] dest, input bit ld, input bit pcsrc, input bit mw);
        id_valid    = v;
        id_rs       = rs;
        id_uses_rs  = urs;
        id_rt       = rt;
        id_uses_rt  = urt;
        id_regwrite = rw;
        id_dest     = dest;
        id_readdmem = ld;
        ex_pcsrc    = pcsrc;
        mem_wait    = mw;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        set_in(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    endtask

    task automatic alu(input bit [4:0] dest, input bit [4:0] rs, input bit urs,
                       input bit [4:0] rt, input bit urt);
        set_in(1, rs, urs, rt, urt, 1, dest, 0, 0, 0);
    endtask

    task automatic load(input bit [4:0] dest, input bit [4:0] base);
        set_in(1, base, 1, 5'd0, 0, 1, dest, 1, 0, 0);
    endtask

    int exp_sat [6] = '{1, 2, 3, 3, 3, 3};

    initial begin
        reset     = 1'b0;
        reset2    = 1'b0;
        mem_wait2 = 1'b0;
        set_in(1, 5'd1, 1, 5'd2, 1, 1, 5'd3, 0, 0, 0);
        cmp_on = 1'b1;
        #2;
        check("rst_pc_en",   32'(pc_en),       0);
        check("rst_ifid_en", 32'(ifid_en),     0);
        check("rst_fwd_a",   32'(fwd_a),       0);
        check("rst_fwd_b",   32'(fwd_b),       0);
        check("rst_cnt",     32'(stall_count), 0);
        tick();
        tick();
        check("rst_cnt_held", 32'(stall_count), 0);
        reset = 1'b1;
        #1;
        check("run_pc_en", 32'(pc_en), 1);
        tick();

        // forwarding from EX, from MEM, and never for r0
        nop(); tick();
        alu(5'd3, 5'd0, 0, 5'd0, 0); tick();
        alu(5'd4, 5'd3, 1, 5'd0, 0); tick();
        check("fwd_ex_a", 32'(fwd_a), 1);
        nop(); tick(); nop(); tick();
        alu(5'd3, 5'd0, 0, 5'd0, 0); tick();
        alu(5'd6, 5'd1, 1, 5'd2, 1); tick();
        alu(5'd4, 5'd3, 1, 5'd0, 0); tick();
        check("fwd_mem_a", 32'(fwd_a), 2);
        nop(); tick(); nop(); tick();
        alu(5'd0, 5'd0, 0, 5'd0, 0); tick();
        alu(5'd4, 5'd0, 1, 5'd0, 0); tick();
        check("fwd_r0_a", 32'(fwd_a), 0);
        alu(5'd3, 5'd0, 0, 5'd0, 0); tick();
        alu(5'd3, 5'd0, 0, 5'd0, 0); tick();
        alu(5'd4, 5'd3, 1, 5'd3, 1); tick();
        check("fwd_youngest_a", 32'(fwd_a), 1);
        check("fwd_youngest_b", 32'(fwd_b), 1);
        alu(5'd7, 5'd0, 0, 5'd0, 0); tick();
        alu(5'd8, 5'd0, 0, 5'd7, 0); tick();
        check("fwd_unused_b", 32'(fwd_b), 0);

        // load-use: exactly one bubble, then forward from WB
        nop(); tick(); nop(); tick();
        load(5'd5, 5'd1); tick();
        alu(5'd8, 5'd0, 0, 5'd5, 1);
        #1;
        check("lu_pc_en",      32'(pc_en),      0);
        check("lu_ifid_en",    32'(ifid_en),    0);
        check("lu_idex_flush", 32'(idex_flush), 1);
        check("lu_ifid_flush", 32'(ifid_flush), 0);
        tick();
        #1;
        check("lu_resume_pc_en", 32'(pc_en),       1);
        check("lu_cnt",          32'(stall_count), 1);
        tick();
        check("lu_fwd_b", 32'(fwd_b), 2);

        // branch taken in the same cycle as a load-use: flush wins, no stall
        nop(); tick(); nop(); tick();
        load(5'd5, 5'd1); tick();
        set_in(1, 5'd5, 1, 5'd0, 0, 1, 5'd9, 0, 1, 0);
        #1;
        check("br_ifid_flush", 32'(ifid_flush), 1);
        check("br_idex_flush", 32'(idex_flush), 1);
        check("br_pc_en",      32'(pc_en),      1);
        tick();
        check("br_cnt",   32'(stall_count), 1);
        check("br_fwd_a", 32'(fwd_a),       0);

        // mem_wait holds everything for 3 cycles, flush only after it drops
        alu(5'd9, 5'd0, 0, 5'd0, 0); tick();
        alu(5'd10, 5'd9, 1, 5'd0, 0); tick();
        check("fz_pre_fwd_a", 32'(fwd_a), 1);
        set_in(1, 5'd9, 1, 5'd0, 0, 1, 5'd11, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("fz_pc_en",      32'(pc_en),      0);
            check("fz_ifid_flush", 32'(ifid_flush), 0);
            check("fz_idex_flush", 32'(idex_flush), 0);
            tick();
            check("fz_fwd_a_held", 32'(fwd_a),       1);
            check("fz_cnt",        32'(stall_count), 2 + i);
        end
        set_in(1, 5'd9, 1, 5'd0, 0, 1, 5'd11, 0, 1, 0);
        #1;
        check("fz_after_ifid_flush", 32'(ifid_flush), 1);
        check("fz_after_idex_flush", 32'(idex_flush), 1);
        check("fz_after_pc_en",      32'(pc_en),      1);
        tick();
        check("fz_after_fwd_a", 32'(fwd_a),       0);
        check("fz_after_cnt",   32'(stall_count), 4);

        // asynchronous reset in the middle of a load-use stall
        nop(); tick();
        load(5'd5, 5'd1); tick();
        alu(5'd8, 5'd0, 0, 5'd5, 1);
        #1;
        check("ar_pre_pc_en", 32'(pc_en), 0);
        reset = 1'b0;
        #1;
        check("ar_cnt",        32'(stall_count), 0);
        check("ar_pc_en",      32'(pc_en),       0);
        check("ar_idex_flush", 32'(idex_flush),  0);
        reset = 1'b1;
        #1;
        check("ar_release_pc_en", 32'(pc_en),      1);
        check("ar_release_idex",  32'(idex_flush), 0);
        tick();
        check("ar_release_cnt", 32'(stall_count), 0);

        // CNT_W=2 instance: saturation and asynchronous clear
        nop();
        reset2    = 1'b1;
        mem_wait2 = 1'b1;
        #1;
        check("sat_pc_en", 32'(pc_en2), 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("sat_cnt", 32'(stall_count2), exp_sat[i]);
        end
        reset2 = 1'b0;
        #1;
        check("sat_async_clr", 32'(stall_count2), 0);
        check("sat_rst_pc_en", 32'(pc_en2),       0);
        tick();
        check("sat_rst_cnt_held", 32'(stall_count2), 0);

        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
